t_vga_v1_pio_in: RTL and testbench
==================================

T_VGA_V1_PIO_IN -- requirements
Module: t_vga_v1_pio_in

Interface
REQ-001 SHALL have parameter WIDTH, default 2, input port width (1..32).
REQ-002 SHALL have parameter EDGE_MODE, default 0, edge type captured: 0 rising, 1 falling, 2 any.
REQ-003 SHALL have parameter DEBOUNCE, default 0, stable cycles required before a filtered bit changes; 0 bypasses the filter.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port address  input  2  Avalon-MM register select.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port in_port  input  WIDTH  asynchronous external inputs.
REQ-011 SHALL have port readdata  output  32  registered read data.
REQ-012 SHALL have port irq  output  1  level interrupt request.

Function
REQ-013 SHALL pass each in_port bit through a two-flop synchronizer (sync1, sync2).
REQ-014 SHALL, for DEBOUNCE=0, use filtered = sync2 directly.
REQ-015 SHALL, for DEBOUNCE>0, keep a per-bit counter: reset to 0 when sync2 equals filtered; otherwise increment; when sync2 still differs and count equals DEBOUNCE-1, load filtered from sync2 and clear count.
REQ-016 SHALL update a filtered bit exactly 2+DEBOUNCE clocks after a stable in_port change; any glitch shorter than DEBOUNCE cycles in the sync2 domain SHALL not change it.
REQ-017 SHALL register filtered into prev each clock; edge per bit: rising = filtered & ~prev, falling = ~filtered & prev, any = filtered ^ prev, selected by EDGE_MODE.
REQ-018 SHALL set edge_capture[i] on the clock following a detected edge on bit i.
REQ-019 SHALL clear edge_capture[i] on a write (chipselect=1, write_n=0) to address 3 with writedata[i]=1; bits written 0 are unchanged.
REQ-020 SHALL, on a simultaneous set and clear of the same bit, leave it set.
REQ-021 SHALL load irq_mask[WIDTH-1:0] from writedata on a write to address 2.
REQ-022 SHALL ignore writes to addresses 0 and 1.
REQ-023 SHALL drive irq = OR of (edge_capture & irq_mask), combinational from registers, no added latency.
REQ-024 SHALL register readdata every clock (irrespective of chipselect) from address: 0 filtered, 1 zero, 2 irq_mask, 3 edge_capture; bits 31..WIDTH zero; read latency 1 clock.
REQ-025 SHALL make a clear-on-write at address 3 visible in readdata on the second clock after the write.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, clear sync1, sync2, filtered, prev, debounce counters, irq_mask, edge_capture and readdata to 0; irq therefore 0.
REQ-027 SHALL treat an input held high through reset as a normal 0->1 transition after release (captured if rising/any mode), not suppressed.
REQ-028 SHALL, on reset asserted mid-debounce or mid-write, discard the in-flight count/write with no partial update.

Structure
REQ-029 SHALL place register address constants (ADDR_DATA=0, ADDR_DIR=1, ADDR_MASK=2, ADDR_EDGE=3) and the EDGE_MODE encoding in shared package t_vga_v1_pio_pkg.
REQ-030 SHALL implement the per-bit synchronizer plus debounce filter as sub-module t_vga_v1_pio_debounce, instantiated WIDTH times.

Verification
REQ-031 WIDTH=2, DEBOUNCE=0: in_port 00->10 at clock N, address=0 -> readdata=0x2 at N+3.
REQ-032 EDGE_MODE=0, mask=0x1 written: in_port[0] 0->1 -> edge_capture=0x1 at N+3, irq=1; write 0x1 to address 3 -> irq=0 next clock, readdata(addr 3)=0.
REQ-033 DEBOUNCE=4: 3-cycle pulse on in_port[1] -> filtered and edge_capture unchanged; 6-cycle pulse -> filtered bit 1 rises at N+6.
REQ-034 EDGE_MODE=2: clear write to address 3 on the same clock a new edge sets bit 0 -> edge_capture[0] stays 1.
REQ-035 in_port=11 held through reset, EDGE_MODE=0 -> edge_capture=0x3 three clocks after reset release; irq=0 until mask written.
REQ-036 Writes 0xFFFFFFFF to addresses 0 and 1 -> readdata at 0 reflects inputs only, at 1 reads 0; WIDTH=2 mask readback = 0x3.

Source files
------------

// File: rtl/t_vga_v1_pio_pkg.sv
// Shared constants for the PIO input block: register map and edge-mode encoding.
package t_vga_v1_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_DIR  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Per-bit edge detector selected by the EDGE_MODE encoding above.
    function automatic logic edge_bit(input int mode, input logic cur, input logic prv);
        case (mode)
            EDGE_RISE: return cur & ~prv;
            EDGE_FALL: return ~cur & prv;
            default:   return cur ^ prv;
        endcase
    endfunction

endpackage

// File: rtl/t_vga_v1_pio_debounce.sv
// One input bit: two-flop synchronizer followed by an optional stable-count filter.
module t_vga_v1_pio_debounce #(
    parameter int DEBOUNCE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic filtered
);

    logic sync1, sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= in_bit;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            assign filtered = sync2;
        end else begin : g_filt
            localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

            logic [CW-1:0] count;
            logic          filt_q;

            // Any sample matching the current output restarts the count, so
            // only DEBOUNCE consecutive differing samples move the output.
            always_ff @(posedge clk) begin
                if (reset) begin
                    count  <= '0;
                    filt_q <= 1'b0;
                end else if (sync2 == filt_q) begin
                    count <= '0;
                end else if (count == CW'(DEBOUNCE - 1)) begin
                    filt_q <= sync2;
                    count  <= '0;
                end else begin
                    count <= count + CW'(1);
                end
            end

            assign filtered = filt_q;
        end
    endgenerate

endmodule

// File: rtl/t_vga_v1_pio_in.sv
// Avalon-MM PIO input port with synchronized/debounced inputs, edge capture and masked IRQ.
module t_vga_v1_pio_in
    import t_vga_v1_pio_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int EDGE_MODE = 0,
    parameter int DEBOUNCE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] wr_bits;
    logic [31:0]      rd_next;
    logic             wr;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wr_bits   = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            t_vga_v1_pio_debounce #(
                .DEBOUNCE (DEBOUNCE)
            ) u_db (
                .clk      (clk),
                .reset    (reset),
                .in_bit   (in_port[i]),
                .filtered (filtered[i])
            );

            assign edge_det[i] = edge_bit(EDGE_MODE, filtered[i], prev[i]);
        end
    endgenerate

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA: rd_next = 32'(filtered);
            ADDR_MASK: rd_next = 32'(irq_mask);
            ADDR_EDGE: rd_next = 32'(edge_capture);
            default:   rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev         <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
        end else begin
            prev     <= filtered;
            readdata <= rd_next;
            if (wr && address == ADDR_MASK)
                irq_mask <= wr_bits;
            // A new edge wins over a clear landing on the same clock.
            if (wr && address == ADDR_EDGE)
                edge_capture <= (edge_capture & ~wr_bits) | edge_det;
            else
                edge_capture <= edge_capture | edge_det;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_t_vga_v1_pio_in.sv
// Directed bench: rising/no-debounce, rising/debounce-4 and any-edge instances on a shared bus.
module tb_t_vga_v1_pio_in;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [1:0]  in_port;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    t_vga_v1_pio_in #(.WIDTH(2), .EDGE_MODE(0), .DEBOUNCE(0)) u_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a)
    );

    t_vga_v1_pio_in #(.WIDTH(2), .EDGE_MODE(0), .DEBOUNCE(4)) u_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_b), .irq(irq_b)
    );

    t_vga_v1_pio_in #(.WIDTH(2), .EDGE_MODE(2), .DEBOUNCE(0)) u_c (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_c), .irq(irq_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 2'b00;
        tick(3);
        chk("rst_rd_a", rd_a, 0);
        chk("rst_rd_b", rd_b, 0);
        chk("rst_irq_a", 32'(irq_a), 0);
        chk("rst_irq_c", 32'(irq_c), 0);
        reset = 1'b0;
        tick(2);

        // Stable change: 2-clock sync + 1-clock read on u_a, +4 debounce on u_b.
        in_port = 2'b10;
        tick(2);
        chk("data_lat_n2", rd_a, 0);
        tick();
        chk("data_lat_n3", rd_a, 2);
        tick(3);
        chk("db_n6", rd_b, 0);
        tick();
        chk("db_n7", rd_b, 2);

        // Rising edge on bit 0 with mask 1, then clear-on-write.
        bus_wr(2'd3, 32'hFFFF_FFFF);
        bus_wr(2'd2, 32'h1);
        address = 2'd3;
        in_port = 2'b11;
        tick(2);
        chk("irq_before", 32'(irq_a), 0);
        tick();
        chk("irq_set", 32'(irq_a), 1);
        tick();
        chk("edge_rd", rd_a, 1);
        bus_wr(2'd3, 32'h1);
        chk("irq_clr", 32'(irq_a), 0);
        tick();
        chk("edge_rd_clr", rd_a, 0);

        // 3-cycle glitch on bit 1: u_b filters it, u_a captures it.
        in_port = 2'b00;
        tick(10);
        bus_wr(2'd3, 32'hFFFF_FFFF);
        address = 2'd0;
        in_port = 2'b10;
        tick(3);
        in_port = 2'b00;
        tick(8);
        chk("glitch_filt_b", rd_b, 0);
        address = 2'd3;
        tick();
        chk("glitch_edge_b", rd_b, 0);
        chk("glitch_edge_a", rd_a, 2);

        // 6-cycle pulse passes the filter.
        address = 2'd0;
        in_port = 2'b10;
        tick(6);
        in_port = 2'b00;
        chk("pulse6_n6", rd_b, 0);
        tick();
        chk("pulse6_n7", rd_b, 2);
        tick(10);

        // Clear landing on the same clock as a new edge: bit stays set.
        bus_wr(2'd3, 32'hFFFF_FFFF);
        address = 2'd3;
        in_port = 2'b01;
        tick(2);
        bus_wr(2'd3, 32'h1);
        tick();
        chk("setclr_c", rd_c, 1);
        chk("setclr_a", rd_a, 1);
        bus_wr(2'd3, 32'h1);
        tick();
        chk("clr_alone_c", rd_c, 0);

        // Writes to data/dir are ignored; mask readback width-limited.
        bus_wr(2'd0, 32'hFFFF_FFFF);
        bus_wr(2'd1, 32'hFFFF_FFFF);
        address = 2'd1;
        tick();
        chk("dir_rd", rd_a, 0);
        address = 2'd0;
        tick();
        chk("data_rd", rd_a, 1);
        bus_wr(2'd2, 32'hFFFF_FFFF);
        address = 2'd2;
        tick();
        chk("mask_rd", rd_a, 3);

        // Inputs held high through reset, with a mask write attempted in reset.
        in_port    = 2'b11;
        reset      = 1'b1;
        address    = 2'd2;
        writedata  = 32'hFF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(2);
        chipselect = 1'b0;
        write_n    = 1'b1;
        chk("rst2_rd", rd_a, 0);
        chk("rst2_irq", 32'(irq_a), 0);
        reset   = 1'b0;
        address = 2'd3;
        tick(3);
        chk("post_rst_r3", rd_a, 0);
        chk("post_rst_irq", 32'(irq_a), 0);
        tick();
        chk("post_rst_edge", rd_a, 3);
        address = 2'd2;
        tick();
        chk("post_rst_mask", rd_a, 0);
        bus_wr(2'd2, 32'h3);
        chk("post_rst_irq_on", 32'(irq_a), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
